// File: rtl/mult_div_unit_pkg.sv
// Shared constants, state encoding and operand helpers for the multiply/divide unit.
package mult_div_unit_pkg;

    localparam int DATA_W     = 32;
    localparam int ITER_COUNT = 32;
    localparam int CNT_W      = $clog2(ITER_COUNT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_e;

    // Two's-complement magnitude; 0x80000000 maps to itself, read as unsigned 2^31.
    function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] v);
        return v[DATA_W-1] ? (~v + DATA_W'(1)) : v;
    endfunction

    function automatic logic [DATA_W-1:0] negate_if(input logic neg, input logic [DATA_W-1:0] v);
        return neg ? (~v + DATA_W'(1)) : v;
    endfunction

endpackage

// File: rtl/mult_div_unit_div_restore_step.sv
// One restoring-division iteration: shift the next dividend bit in, subtract if it fits.
module div_restore_step
    import mult_div_unit_pkg::*;
#(
    parameter int W = DATA_W
) (
    input  logic [W-1:0] rem_in,
    input  logic [W-1:0] quo_in,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] rem_out,
    output logic [W-1:0] quo_out
);

    logic [W:0] shifted_s;
    logic       quo_bit_s;

    // Remainder stays below the divisor magnitude, so the shifted value fits in W+1 bits.
    always_comb begin
        shifted_s = {rem_in, quo_in[W-1]};
        if (shifted_s >= {1'b0, divisor}) begin
            rem_out   = W'(shifted_s - {1'b0, divisor});
            quo_bit_s = 1'b1;
        end else begin
            rem_out   = shifted_s[W-1:0];
            quo_bit_s = 1'b0;
        end
        quo_out = {quo_in[W-2:0], quo_bit_s};
    end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative signed multiply (radix-2 Booth) and signed restoring divide feeding HI/LO.
module mult_div_unit #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_mult,
    input  logic              start_div,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo,
    output logic              busy,
    output logic              done,
    output logic              div_zero
);
    import mult_div_unit_pkg::*;

    state_e            state_r, next_state_s;
    logic [DATA_W-1:0] op_a_r, op_b_r, q_r, hi_r, lo_r;
    logic [DATA_W:0]   acc_r;
    logic              q1_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              busy_r, done_r, div_zero_r;
    logic              busy_next_s, done_next_s, div_zero_next_s;
    logic              accept_mult_s, accept_div_s, div_by_zero_s, last_step_s;
    logic [DATA_W:0]   mcand_ext_s, booth_sum_s, booth_acc_next_s;
    logic [DATA_W-1:0] booth_q_next_s;
    logic [DATA_W-1:0] divisor_mag_s, div_rem_next_s, div_quo_next_s;
    logic [DATA_W-1:0] div_rem_signed_s, div_quo_signed_s;

    assign hi       = hi_r;
    assign lo       = lo_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign div_zero = div_zero_r;

    // Start decode: multiply wins over divide, starts only count in IDLE.
    always_comb begin
        accept_mult_s = (state_r == IDLE) && start_mult;
        accept_div_s  = (state_r == IDLE) && !start_mult && start_div && (b != {DATA_W{1'b0}});
        div_by_zero_s = (state_r == IDLE) && !start_mult && start_div && (b == {DATA_W{1'b0}});
        last_step_s   = (cnt_r == CNT_W'(ITER_COUNT - 1));
    end

    // Booth step on a one-bit-wider accumulator so adding/subtracting -2^31 cannot overflow.
    always_comb begin
        mcand_ext_s = {op_a_r[DATA_W-1], op_a_r};
        case ({q_r[0], q1_r})
            2'b01:   booth_sum_s = acc_r + mcand_ext_s;
            2'b10:   booth_sum_s = acc_r - mcand_ext_s;
            default: booth_sum_s = acc_r;
        endcase
        booth_acc_next_s = {booth_sum_s[DATA_W], booth_sum_s[DATA_W:1]};
        booth_q_next_s   = {booth_sum_s[0], q_r[DATA_W-1:1]};
    end

    assign divisor_mag_s = magnitude(op_b_r);

    div_restore_step #(.W(DATA_W)) u_div_step (
        .rem_in  (acc_r[DATA_W-1:0]),
        .quo_in  (q_r),
        .divisor (divisor_mag_s),
        .rem_out (div_rem_next_s),
        .quo_out (div_quo_next_s)
    );

    assign div_quo_signed_s = negate_if(op_a_r[DATA_W-1] ^ op_b_r[DATA_W-1], div_quo_next_s);
    assign div_rem_signed_s = negate_if(op_a_r[DATA_W-1], div_rem_next_s);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_mult_s) begin
                    next_state_s = MULT;
                end else if (accept_div_s) begin
                    next_state_s = DIV;
                end else if (div_by_zero_s) begin
                    next_state_s = DONE;
                end else begin
                    next_state_s = IDLE;
                end
            end
            MULT:    next_state_s = last_step_s ? DONE : MULT;
            DIV:     next_state_s = last_step_s ? DONE : DIV;
            DONE:    next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // Output decode of the upcoming state, registered below so flags align with it.
    always_comb begin
        busy_next_s     = (next_state_s == MULT) || (next_state_s == DIV);
        done_next_s     = (next_state_s == DONE);
        div_zero_next_s = div_by_zero_s;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            div_zero_r <= 1'b0;
        end else begin
            busy_r     <= busy_next_s;
            done_r     <= done_next_s;
            div_zero_r <= div_zero_next_s;
        end
    end

    // Operand latch, iteration datapath and HI/LO result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_a_r <= {DATA_W{1'b0}};
            op_b_r <= {DATA_W{1'b0}};
            acc_r  <= {(DATA_W+1){1'b0}};
            q_r    <= {DATA_W{1'b0}};
            q1_r   <= 1'b0;
            cnt_r  <= {CNT_W{1'b0}};
            hi_r   <= {DATA_W{1'b0}};
            lo_r   <= {DATA_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_mult_s || accept_div_s) begin
                        op_a_r <= a;
                        op_b_r <= b;
                        acc_r  <= {(DATA_W+1){1'b0}};
                        q_r    <= accept_mult_s ? b : magnitude(a);
                        q1_r   <= 1'b0;
                        cnt_r  <= {CNT_W{1'b0}};
                    end
                end
                MULT: begin
                    acc_r <= booth_acc_next_s;
                    q_r   <= booth_q_next_s;
                    q1_r  <= q_r[0];
                    cnt_r <= cnt_r + CNT_W'(1);
                    if (last_step_s) begin
                        hi_r <= booth_acc_next_s[DATA_W-1:0];
                        lo_r <= booth_q_next_s;
                    end
                end
                DIV: begin
                    acc_r <= {1'b0, div_rem_next_s};
                    q_r   <= div_quo_next_s;
                    cnt_r <= cnt_r + CNT_W'(1);
                    if (last_step_s) begin
                        hi_r <= div_rem_signed_s;
                        lo_r <= div_quo_signed_s;
                    end
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: directed and random multiply/divide operations.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset, start_mult, start_div;
    logic [31:0] a, b, hi, lo;
    logic        busy, done, div_zero;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          lat;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] model_hi = 32'h0;
    logic [31:0] model_lo = 32'h0;

    always #5 clk = ~clk;

    mult_div_unit #(.DATA_W(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .start_mult (start_mult),
        .start_div  (start_div),
        .a          (a),
        .b          (b),
        .hi         (hi),
        .lo         (lo),
        .busy       (busy),
        .done       (done),
        .div_zero   (div_zero)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // Reference model: native signed arithmetic, truncating division, explicit overflow case.
    task automatic push_expected(input logic sm, input logic [31:0] av, input logic [31:0] bv);
        exp_t   e;
        int     sa, sb, qv, rv;
        longint p;
        sa = int'(signed'(av));
        sb = int'(signed'(bv));
        e.dz  = 1'b0;
        e.lat = 33;
        if (sm) begin
            p = longint'(sa) * longint'(sb);
            model_hi = p[63:32];
            model_lo = p[31:0];
        end else if (bv == 32'h0) begin
            e.dz  = 1'b1;
            e.lat = 1;
        end else begin
            if (av == 32'h8000_0000 && bv == 32'hFFFF_FFFF) begin
                qv = sa;
                rv = 0;
            end else begin
                qv = sa / sb;
                rv = sa % sb;
            end
            model_hi = rv;
            model_lo = qv;
        end
        e.hi = model_hi;
        e.lo = model_lo;
        sb_q.push_back(e);
    endtask

    task automatic wait_done(input string tag, input int n_start);
        exp_t e;
        int   n;
        n = n_start;
        while (!done && n < 40) begin
            tick();
            n++;
        end
        e = sb_q.pop_front();
        check({tag, "_latency"}, 64'(n), 64'(e.lat));
        check({tag, "_hi"}, {32'h0, hi}, {32'h0, e.hi});
        check({tag, "_lo"}, {32'h0, lo}, {32'h0, e.lo});
        check({tag, "_div_zero"}, {63'h0, div_zero}, {63'h0, e.dz});
        check({tag, "_busy_in_done"}, {63'h0, busy}, 64'h0);
    endtask

    task automatic run_op(input string tag, input logic sm, input logic sd,
                          input logic [31:0] av, input logic [31:0] bv);
        a = av;
        b = bv;
        start_mult = sm;
        start_div  = sd;
        push_expected(sm, av, bv);
        tick();
        start_mult = 1'b0;
        start_div  = 1'b0;
        if (sm || bv != 32'h0) begin
            check({tag, "_busy"}, {63'h0, busy}, 64'h1);
        end
        wait_done(tag, 1);
        tick();
        check({tag, "_done_drop"}, {63'h0, done}, 64'h0);
    endtask

    initial begin
        int          n;
        int          seen;
        logic [31:0] ra, rb;

        reset = 1'b1; start_mult = 1'b0; start_div = 1'b0; a = 32'h0; b = 32'h0;
        tick();
        tick();
        reset = 1'b0;
        check("reset_state", {hi, lo}, 64'h0);
        check("reset_flags", {61'h0, busy, done, div_zero}, 64'h0);

        run_op("mul_7_m3", 1'b1, 1'b0, 32'h0000_0007, 32'hFFFF_FFFD);
        check("mul_7_m3_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
        run_op("mul_min_min", 1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000);
        check("mul_min_min_const", {hi, lo}, 64'h4000_0000_0000_0000);
        run_op("div_m7_2", 1'b0, 1'b1, 32'hFFFF_FFF9, 32'h0000_0002);
        check("div_m7_2_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op("div_7_m2", 1'b0, 1'b1, 32'h0000_0007, 32'hFFFF_FFFE);
        check("div_7_m2_const", {hi, lo}, 64'h0000_0001_FFFF_FFFD);
        run_op("div_by_zero", 1'b0, 1'b1, 32'h0000_0005, 32'h0000_0000);
        check("div_by_zero_hold", {hi, lo}, 64'h0000_0001_FFFF_FFFD);
        run_op("div_ovf", 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        check("div_ovf_const", {hi, lo}, 64'h0000_0000_8000_0000);
        run_op("both_starts", 1'b1, 1'b1, 32'h0000_007B, 32'hFFFF_FFD3);

        for (int i = 0; i < 6; i++) begin
            ra = $urandom;
            rb = $urandom;
            run_op("rand_mul", 1'b1, 1'b0, ra, rb);
            rb = 32'($urandom_range(1, 1000));
            if (i % 2 == 1) rb = ~rb + 32'h1;
            run_op("rand_div", 1'b0, 1'b1, ra, rb);
        end

        // A divide request while a multiply is running must not disturb it.
        a = 32'h0000_1234; b = 32'hFFFF_0F0F; start_mult = 1'b1;
        push_expected(1'b1, a, b);
        tick();
        start_mult = 1'b0;
        n = 1;
        while (n < 5) begin tick(); n++; end
        a = 32'h0000_0063; b = 32'h0000_0007; start_div = 1'b1;
        tick(); n++;
        start_div = 1'b0;
        wait_done("busy_ignore", n);

        // A start during the DONE cycle is dropped.
        a = 32'h0000_0002; b = 32'h0000_0003; start_mult = 1'b1;
        tick();
        start_mult = 1'b0;
        check("done_start_busy", {63'h0, busy}, 64'h0);
        check("done_start_done", {63'h0, done}, 64'h0);
        check("done_start_hold", {hi, lo}, {model_hi, model_lo});

        // Reset in the middle of a multiply aborts it without a done pulse.
        a = 32'h0001_2345; b = 32'h0000_0777; start_mult = 1'b1;
        tick();
        start_mult = 1'b0;
        n = 1;
        while (n < 10) begin tick(); n++; end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_hi = 32'h0;
        model_lo = 32'h0;
        check("abort_busy", {63'h0, busy}, 64'h0);
        check("abort_done", {63'h0, done}, 64'h0);
        check("abort_hilo", {hi, lo}, 64'h0);
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (done) seen++;
        end
        check("abort_no_done", 64'(seen), 64'h0);

        run_op("post_reset_div", 1'b0, 1'b1, 32'h0000_0064, 32'h0000_0007);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
